// File: rtl/alu_cmd_ctrl.sv
// Command FIFO + sequencer + result collector in front of the registered 16-bit ALU.
// Optional flag-consistency checker enabled by defining ALU_CMD_CTRL_FLAG_CHK_EN.
module alu_cmd_ctrl #(
  parameter int DATA_W = 16,
  parameter int FUN_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [FUN_W-1:0]  cmd_fun,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              c_out,
  input  logic              arith_flag,
  input  logic              logic_flag,
  input  logic              cmp_flag,
  input  logic              shift_flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cout,
  output logic [3:0]        res_flags,
  output logic [15:0]       done_cnt,
  output logic              busy,
  output logic              flag_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [FUN_W-1:0]  fun;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t     state, state_nxt;
  cmd_t       mem [DEPTH];
  cmd_t       head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic       full, empty, push, pop;
  logic [3:0] flags_in;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != ST_IDLE) || !empty;
  assign flags_in  = {shift_flag, cmp_flag, logic_flag, arith_flag};

  // NOTE: the storage array has no reset; only pointers/count must be defined, which
  // keeps the array mappable to plain registers or RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{fun: cmd_fun, b: cmd_b, a: cmd_a};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaults first, so no path through the case leaves a variable unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (res_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ST_DRIVE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_flags <= '0;
      done_cnt  <= '0;
    end else begin
      if (pop) begin
        alu_a   <= head.a;
        alu_b   <= head.b;
        alu_fun <= head.fun;
      end
      // The ALU registered its result on the DRIVE->WAIT edge; it is valid now.
      if (state == ST_WAIT) begin
        res_valid <= 1'b1;
        res_data  <= alu_out;
        res_cout  <= c_out;
        res_flags <= flags_in;
        done_cnt  <= done_cnt + 16'd1;
      end else if (state == ST_HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_CMD_CTRL_FLAG_CHK_EN
  logic multi_flag;

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign multi_flag = |(flags_in & (flags_in - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             flag_err <= 1'b0;
    else if (state == ST_WAIT && multi_flag) flag_err <= 1'b1;
  end
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered adder standing in for the ALU.
module tb_alu_cmd_ctrl;

  localparam int DATA_W = 16;
  localparam int FUN_W  = 4;
  localparam int DEPTH  = 4;

`ifdef ALU_CMD_CTRL_FLAG_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [DATA_W-1:0] cmd_a, cmd_b;
  logic [FUN_W-1:0]  cmd_fun;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [FUN_W-1:0]  alu_fun;
  logic [DATA_W-1:0] alu_out;
  logic              c_out;
  logic              arith_flag, logic_flag, cmp_flag, shift_flag;
  logic              res_valid, res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_cout;
  logic [3:0]        res_flags;
  logic [15:0]       done_cnt;
  logic              busy, flag_err;
  logic              bad_flags;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.DATA_W(DATA_W), .FUN_W(FUN_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_fun    (cmd_fun),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fun    (alu_fun),
    .alu_out    (alu_out),
    .c_out      (c_out),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_cout   (res_cout),
    .res_flags  (res_flags),
    .done_cnt   (done_cnt),
    .busy       (busy),
    .flag_err   (flag_err)
  );

  // Stub ALU: one-clock registered adder; class flags are combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {c_out, alu_out} <= '0;
    else        {c_out, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
  end
  assign arith_flag = 1'b1;
  assign logic_flag = 1'b0;
  assign cmp_flag   = bad_flags;
  assign shift_flag = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    int  n = 0;
    logic ok = 1'b0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_fun   = fun;
    cmd_valid = 1'b1;
    while (!ok && n < 20) begin
      ok = cmd_ready;
      step();
      n++;
    end
    cmd_valid = 1'b0;
    if (!ok) check("push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
  endtask

  initial begin
    int   acc;
    int   exp_val;
    int   last_cyc;
    logic got6;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_fun   = '0;
    res_ready = 1'b0;
    bad_flags = 1'b0;
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done_cnt",  32'(done_cnt),  32'd0);
    check("rst_flag_err",  32'(flag_err),  32'd0);
    rst_n = 1'b1;
    step();

    // Single op with exact latency
    res_ready = 1'b1;
    cmd_a = 16'd20; cmd_b = 16'd15; cmd_fun = 4'd0; cmd_valid = 1'b1;
    check("single_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("single_busy", 32'(busy), 32'd1);
    step();
    check("single_alu_a", 32'(alu_a), 32'd20);
    check("single_alu_b", 32'(alu_b), 32'd15);
    check("single_e1_valid", 32'(res_valid), 32'd0);
    step();
    check("single_e2_valid", 32'(res_valid), 32'd0);
    step();
    check("single_e3_valid", 32'(res_valid), 32'd1);
    check("single_data",     32'(res_data),  32'd35);
    check("single_cout",     32'(res_cout),  32'd0);
    check("single_flags",    32'(res_flags), 32'b0001);
    check("single_done",     32'(done_cnt),  32'd1);
    step();
    check("single_consumed", 32'(res_valid), 32'd0);

    // Carry out
    push_one(16'hFFFF, 16'h0001, 4'd0);
    wait_result("carry");
    check("carry_data", 32'(res_data), 32'd0);
    check("carry_cout", 32'(res_cout), 32'd1);
    step();

    // Fill with result port stalled: DEPTH + 1 accepted
    res_ready = 1'b0;
    acc = 0;
    cmd_b = '0;
    cmd_fun = '0;
    for (int i = 1; i <= 6; i++) begin
      cmd_a     = 16'(i);
      cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      step();
    end
    check("fill_accepted", 32'(acc),       32'd5);
    check("fill_ready",    32'(cmd_ready), 32'd0);
    check("fill_valid",    32'(res_valid), 32'd1);

    // Backpressure: everything frozen
    for (int i = 0; i < 5; i++) begin
      check("bp_data",  32'(res_data),  32'd1);
      check("bp_flags", 32'(res_flags), 32'b0001);
      check("bp_alu_a", 32'(alu_a),     32'd1);
      check("bp_done",  32'(done_cnt),  32'd3);
      check("bp_valid", 32'(res_valid), 32'd1);
      step();
    end

    // Release: in-order results 3 cycles apart, held 6th command gets in
    res_ready = 1'b1;
    exp_val   = 1;
    last_cyc  = -1;
    got6      = 1'b0;
    for (int cyc = 0; cyc < 60 && exp_val <= 6; cyc++) begin
      logic take6;
      take6 = cmd_valid && cmd_ready;
      if (res_valid) begin
        check("order_data", 32'(res_data), 32'(exp_val));
        if (last_cyc >= 0) check("order_spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        exp_val++;
      end
      step();
      if (take6) begin
        cmd_valid = 1'b0;
        got6      = 1'b1;
      end
    end
    check("order_all_seen", 32'(exp_val), 32'd7);
    check("order_6th_acc",  32'(got6),    32'd1);
    for (int n = 0; n < 20 && busy; n++) step();
    check("order_idle", 32'(busy),     32'd0);
    check("order_done", 32'(done_cnt), 32'd8);

    // Flag consistency
    bad_flags = 1'b1;
    push_one(16'd1, 16'd2, 4'd0);
    wait_result("flg_bad");
    check("flg_bad_flags", 32'(res_flags), 32'b0101);
    check("flg_bad_data",  32'(res_data),  32'd3);
    check("flg_bad_err",   32'(flag_err),  32'(EXP_ERR));
    step();
    bad_flags = 1'b0;
    push_one(16'd4, 16'd4, 4'd0);
    wait_result("flg_ok");
    check("flg_ok_flags", 32'(res_flags), 32'b0001);
    check("flg_ok_data",  32'(res_data),  32'd8);
    check("flg_sticky",   32'(flag_err),  32'(EXP_ERR));
    step();

    // Reset mid-burst
    res_ready = 1'b0;
    push_one(16'd9,  16'd1, 4'd3);
    push_one(16'd10, 16'd1, 4'd3);
    push_one(16'd11, 16'd1, 4'd3);
    rst_n = 1'b0;
    step();
    step();
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mrst_res_valid", 32'(res_valid), 32'd0);
    check("mrst_alu_a",     32'(alu_a),     32'd0);
    check("mrst_alu_fun",   32'(alu_fun),   32'd0);
    check("mrst_done",      32'(done_cnt),  32'd0);
    check("mrst_busy",      32'(busy),      32'd0);
    check("mrst_flag_err",  32'(flag_err),  32'd0);
    rst_n = 1'b1;
    step();
    res_ready = 1'b1;
    push_one(16'd7, 16'd8, 4'd0);
    wait_result("post_rst");
    check("post_rst_data", 32'(res_data), 32'd15);
    check("post_rst_done", 32'(done_cnt), 32'd1);
    step();
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
